iq_mixer_cic: RTL

- Downstream consumer of the square/table NCO's 8-bit signed sin/cos outputs.
- Mixes the 1-bit RF sample stream (comparator or 1-bit ADC) against the NCO quadrature outputs to form I/Q at baseband.
- Low-pass filters and decimates each rail with a 3rd-order CIC (differential delay 1).
- Delivers strobed I/Q words to the AM envelope/demod stage.

---
 rtl/iq_mixer_cic.sv | 103 ++++++++++
 1 files changed

// File: rtl/iq_mixer_cic.sv
// 1-bit RF x NCO quadrature mixer feeding a 3rd-order, differential-delay-1 CIC decimator per rail.
// The I rail mixes with cos and the Q rail with sin; both rails share one decimation counter and strobe pipeline.
module iq_mixer_cic #(
    parameter int BITS       = 8,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_BITS   = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       rf_in,
    input  logic signed [BITS-1:0]     sin,
    input  logic signed [BITS-1:0]     cos,
    output logic signed [OUT_BITS-1:0] i_out,
    output logic signed [OUT_BITS-1:0] q_out,
    output logic                       out_valid
);

    localparam int W    = BITS + 1 + 3 * DECIM_LOG2;
    localparam int NSTG = 3;

    logic [DECIM_LOG2-1:0] cnt_q;
    logic [DECIM_LOG2-1:0] cnt_d;
    logic                  strobe;
    logic [NSTG:0]         en_q;
    logic                  valid_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    assign strobe = &cnt_q;

    // en_q[s-1] advances comb stage s; en_q[NSTG] loads the output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            en_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= {en_q[NSTG-1:0], strobe};
            valid_q <= en_q[NSTG];
        end
    end

    assign out_valid = valid_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rail
        logic signed [BITS-1:0]     lo;
        logic signed [BITS:0]       lo_ext;
        logic signed [BITS:0]       mix_d;
        logic signed [BITS:0]       mix_q;
        logic signed [W-1:0]        integ_q [NSTG];
        logic signed [W-1:0]        comb_q  [NSTG+1];
        logic signed [W-1:0]        dly_q   [NSTG];
        logic signed [OUT_BITS-1:0] out_q;

        assign lo     = (gi == 0) ? cos : sin;
        assign lo_ext = {lo[BITS-1], lo};

        // One extra bit makes negating the most negative NCO code exact.
        always_comb begin
            mix_d = rf_in ? lo_ext : -lo_ext;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                mix_q <= '0;
                out_q <= '0;
                for (int s = 0; s < NSTG; s++) begin
                    integ_q[s] <= '0;
                    dly_q[s]   <= '0;
                end
                for (int s = 0; s <= NSTG; s++) begin
                    comb_q[s] <= '0;
                end
            end else begin
                mix_q      <= mix_d;
                integ_q[0] <= integ_q[0] + {{(W-BITS-1){mix_q[BITS]}}, mix_q};
                for (int s = 1; s < NSTG; s++) begin
                    integ_q[s] <= integ_q[s] + integ_q[s-1];
                end
                if (strobe) begin
                    comb_q[0] <= integ_q[NSTG-1];
                end
                // Integrator wrap is cancelled here as long as W covers the full CIC gain.
                for (int s = 1; s <= NSTG; s++) begin
                    if (en_q[s-1]) begin
                        comb_q[s]  <= comb_q[s-1] - dly_q[s-1];
                        dly_q[s-1] <= comb_q[s-1];
                    end
                end
                if (en_q[NSTG]) begin
                    out_q <= comb_q[NSTG][W-1 -: OUT_BITS];
                end
            end
        end
    end

    assign i_out = g_rail[0].out_q;
    assign q_out = g_rail[1].out_q;

endmodule
